// File: rtl/dmem_defs.sv
// Shared definitions for the data memory responder: FSM encodings, data/lane widths
// and default parameter values.
package dmem_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables, registered read data.
// Read data only changes on an enabled cycle, so it stays stable while the responder holds a response.
module dmem_array
    import dmem_defs::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};
    logic [DATA_W-1:0] rdata_q = '0;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder for the simple processor's data port with a fixed number of wait states.
// Define DMEM_MISALIGN_ERR_EN to flag addr[1:0] != 0 as an access error.
module data_memory_responder
    import dmem_defs::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output state_t            dbg_state_o
);

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic                err_q;
    logic [ADDR_W-1:0]   word_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   ram_rdata;
    logic                accept;
    logic                req_err;

    // The error decision is made from the request as accepted; later input changes are ignored.
    assign req_err = (|req_addr[31:ADDR_W+2]) | (MISALIGN_EN & (|req_addr[1:0]));
    assign accept  = (state_q == ST_IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                word_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset on the ACCESS edge must suppress the write, so the RAM enable is gated by it.
    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .en_i    ((state_q == ST_ACCESS) && !reset),
        .we_i    (we_q && !err_q),
        .be_i    (be_q),
        .addr_i  (word_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign rsp_rdata   = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;
    assign rsp_err     = rsp_valid && err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder (ADDR_W=10, WAIT_CYCLES=2).
module tb_data_memory_responder;
    import dmem_defs::*;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    state_t      dbg_state;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [31:0] got_rdata;
    logic        got_err;

    data_memory_responder #(
        .ADDR_W      (10),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and return right after the acceptance edge, then scramble the inputs.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input string tag);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
        req_be    = 4'hF;
    endtask

    // Wait for rsp_valid; valid follows acceptance edge N after edge N+1+WAIT_CYCLES,
    // i.e. it is first seen on the (WAIT_CYCLES+2)th falling edge after acceptance.
    task automatic wait_rsp(input string tag, output logic [31:0] rdata, output logic err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        check({tag, "_latency"}, 32'(n), 32'(WAIT_CYCLES + 2));
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input string tag,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(we, addr, wdata, be, tag);
        wait_rsp(tag, got_rdata, got_err);
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        complete();
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // Basic store/load
        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "st10", 32'h0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, "ld10", 32'hDEAD_BEEF, 1'b0);

        // Byte-lane merge: 0x11223344 with lanes 0 and 2 from 0xAABBCCDD
        txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, "st20a", 32'h0, 1'b0);
        txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, "st20b", 32'h0, 1'b0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, "ld20", 32'h11BB_33DD, 1'b0);

        // Out-of-range accesses; 0x1010 aliases word 4 in the low bits but must not write it
        txn(1'b0, 32'h0000_1000, 32'h0, 4'h0, "ld_oor", 32'h0, 1'b1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, "ld0", 32'h0, 1'b0);
        txn(1'b1, 32'h0000_1010, 32'h1234_5678, 4'hF, "st_oor", 32'h0, 1'b1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, "ld10_after_oor", 32'hDEAD_BEEF, 1'b0);
        txn(1'b1, 32'h8000_0FFC, 32'h1, 4'hF, "st_hi_bit", 32'h0, 1'b1);
        txn(1'b0, 32'hFFC, 32'h0, 4'h0, "ld_top", 32'h0, 1'b0);

        // Response held for 5 cycles with rsp_ready low
        issue(1'b0, 32'h20, 32'h0, 4'h0, "hold");
        wait_rsp("hold", got_rdata, got_err);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'h11BB_33DD);
            check("hold_err", 32'(rsp_err), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        complete();
        @(negedge clk);
        check("post_hold_req_ready", 32'(req_ready), 32'd1);
        check("post_hold_valid", 32'(rsp_valid), 32'd0);

        // Reset during WAIT abandons the store
        issue(1'b1, 32'h30, 32'h55, 4'hF, "st30");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_err", 32'(rsp_err), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'h0, "ld30", 32'h0, 1'b0);

        // Reset coinciding with the ACCESS edge (acceptance N, ACCESS edge N+3)
        issue(1'b1, 32'h34, 32'h77, 4'hF, "st34");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("accrst_state", 32'(dbg_state), 32'(ST_IDLE));
        txn(1'b0, 32'h34, 32'h0, 4'h0, "ld34", 32'h0, 1'b0);

        // Misaligned store
`ifdef DMEM_MISALIGN_ERR_EN
        txn(1'b1, 32'h42, 32'hCAFE_F00D, 4'hF, "st42", 32'h0, 1'b1);
        txn(1'b0, 32'h40, 32'h0, 4'h0, "ld40", 32'h0, 1'b0);
`else
        txn(1'b1, 32'h42, 32'hCAFE_F00D, 4'hF, "st42", 32'h0, 1'b0);
        txn(1'b0, 32'h40, 32'h0, 4'h0, "ld40", 32'hCAFE_F00D, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
